ex_ls: RTL and testbench

Load/store execution unit. It accepts one memory operation at a time from the load/store buffer's issue port. It computes the effective address and sequences the access byte-by-byte over an 8-bit RAM port with one-cycle read latency. It then broadcasts the completed result (tag + data) on the memory result bus consumed by the reservation stations, load/store buffer and ROB.

---
 rtl/ex_ls_if.sv | 33 +++
 rtl/ex_ls.sv | 182 ++++++++++++++++++
 tb/tb_ex_ls.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_ls_if.sv
// Issue, result-broadcast and byte-RAM signals of the load/store execution unit.
// The slave modport is the unit; the master modport is the buffer/RAM side.
interface ex_ls_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6,
  parameter int MEM_AW = 17
);
  logic              ex_ls_en;
  logic [DATA_W-1:0] ex_src1;
  logic [DATA_W-1:0] ex_src2;
  logic [DATA_W-1:0] ex_reg;
  logic [OP_W-1:0]   ex_lsop;
  logic [TAG_W-1:0]  ex_dest;
  logic              ex_ls_done;
  logic              en_mem_rst;
  logic [TAG_W-1:0]  mem_rst_tag;
  logic [DATA_W-1:0] mem_rst_data;
  logic [MEM_AW-1:0] mem_a;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;

  modport master (
    output ex_ls_en, ex_src1, ex_src2, ex_reg, ex_lsop, ex_dest, mem_din,
    input  ex_ls_done, en_mem_rst, mem_rst_tag, mem_rst_data, mem_a, mem_wr, mem_dout
  );

  modport slave (
    input  ex_ls_en, ex_src1, ex_src2, ex_reg, ex_lsop, ex_dest, mem_din,
    output ex_ls_done, en_mem_rst, mem_rst_tag, mem_rst_data, mem_a, mem_wr, mem_dout
  );
endinterface

// File: rtl/ex_ls.sv
// Load/store execution unit: one op at a time, sequenced byte-by-byte over an
// 8-bit RAM port with one-cycle read latency, result broadcast on the memory bus.
module ex_ls #(
  parameter int              DATA_W   = 32,
  parameter int              TAG_W    = 4,
  parameter int              OP_W     = 6,
  parameter int              MEM_AW   = 17,
  parameter logic [TAG_W-1:0] TAG_FREE = '0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   rdy,
  input  logic   clear,
  ex_ls_if.slave bus
);

  localparam logic [OP_W-1:0] OP_LB  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_LH  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LBU = OP_W'(14);
  localparam logic [OP_W-1:0] OP_LHU = OP_W'(15);
  localparam logic [OP_W-1:0] OP_SB  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SH  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(18);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STORE = 2'd2} state_t;

  function automatic logic [2:0] op_len(input logic [OP_W-1:0] o);
    case (o)
      OP_LB, OP_LBU, OP_SB: op_len = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_len = 3'd2;
      OP_LW, OP_SW:         op_len = 3'd4;
      default:              op_len = 3'd0;
    endcase
  endfunction

  function automatic logic is_load(input logic [OP_W-1:0] o);
    is_load = (o == OP_LB) || (o == OP_LH) || (o == OP_LW) || (o == OP_LBU) || (o == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] o);
    is_store = (o == OP_SB) || (o == OP_SH) || (o == OP_SW);
  endfunction

  function automatic logic [DATA_W-1:0] merge_byte(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] sel,
                                                    input logic [7:0] b);
    merge_byte = word;
    merge_byte[{sel, 3'b000} +: 8] = b;
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [OP_W-1:0] o,
                                                input logic [DATA_W-1:0] raw);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    sb = raw[7:0];
    sh = raw[15:0];
    case (o)
      OP_LB:   extend = DATA_W'(sb);
      OP_LH:   extend = DATA_W'(sh);
      OP_LBU:  extend = {{(DATA_W-8){1'b0}}, raw[7:0]};
      OP_LHU:  extend = {{(DATA_W-16){1'b0}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  state_t             state, state_nxt;
  logic [2:0]         cnt, cnt_nxt, len;
  logic [DATA_W-1:0]  addr, sdata, ldata, ldata_mrg;
  logic [OP_W-1:0]    op;
  logic [TAG_W-1:0]   dest;
  logic               squash, start, fin_load, fin_store, cap;
  logic [7:0]         din_hold, byte_in;
  logic               hold_vld;
  logic [1:0]         bsel;
  logic               en_r;
  logic [TAG_W-1:0]   tag_r;
  logic [DATA_W-1:0]  data_r;

  assign len       = op_len(op);
  assign bsel      = 2'(cnt - 3'd1);
  // The first stall cycle still carries the read data of the last active
  // address; it is parked so the held address does not lose that byte.
  assign byte_in   = hold_vld ? din_hold : bus.mem_din;
  assign ldata_mrg = merge_byte(ldata, bsel, byte_in);
  assign cap       = (state == LOAD) && (cnt != 3'd0) && !clear;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    fin_load  = 1'b0;
    fin_store = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ex_ls_en && !clear) begin
          cnt_nxt = 3'd0;
          if (is_load(bus.ex_lsop)) begin
            state_nxt = LOAD;
            start     = 1'b1;
          end else if (is_store(bus.ex_lsop)) begin
            state_nxt = STORE;
            start     = 1'b1;
          end
        end
      end
      LOAD: begin
        if (clear) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else if (cnt == len) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
          fin_load  = 1'b1;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      STORE: begin
        // A flushed store still writes all bytes; only the completion is dropped.
        if (cnt == len - 3'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
          fin_store = !clear && !squash;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  assign bus.ex_ls_done   = (state == IDLE) && !bus.ex_ls_en;
  assign bus.mem_a        = MEM_AW'(addr + DATA_W'(cnt));
  assign bus.mem_wr       = (state == STORE) && rdy;
  assign bus.mem_dout     = (state == STORE) ? sdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;
  assign bus.en_mem_rst   = en_r;
  assign bus.mem_rst_tag  = tag_r;
  assign bus.mem_rst_data = data_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      addr     <= '0;
      op       <= '0;
      dest     <= '0;
      squash   <= 1'b0;
      hold_vld <= 1'b0;
      en_r     <= 1'b0;
      tag_r    <= TAG_FREE;
      data_r   <= '0;
    end else if (rdy) begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hold_vld <= 1'b0;
      if (start) begin
        addr   <= bus.ex_src1 + bus.ex_src2;
        op     <= bus.ex_lsop;
        dest   <= bus.ex_dest;
        squash <= 1'b0;
      end else if (state == STORE && clear) begin
        squash <= 1'b1;
      end
      en_r   <= fin_load || fin_store;
      tag_r  <= (fin_load || fin_store) ? dest : TAG_FREE;
      data_r <= fin_load ? extend(op, ldata_mrg) : '0;
    end else if (!hold_vld) begin
      hold_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && start) sdata <= bus.ex_reg;
    if (rdy && cap) ldata <= ldata_mrg;
    if (!rdy && !hold_vld) din_hold <= bus.mem_din;
  end

endmodule

// File: tb/tb_ex_ls.sv
// Directed bench for ex_ls: cycle-numbered load/store scenarios against a byte RAM model.
module tb_ex_ls;

  localparam logic [5:0] LB  = 6'd11;
  localparam logic [5:0] LH  = 6'd12;
  localparam logic [5:0] LW  = 6'd13;
  localparam logic [5:0] LBU = 6'd14;
  localparam logic [5:0] SB  = 6'd16;
  localparam logic [5:0] SH  = 6'd17;
  localparam logic [5:0] SW  = 6'd18;

  logic clk, rst, rdy, clear;
  ex_ls_if #(.DATA_W(32), .TAG_W(4), .OP_W(6), .MEM_AW(17)) bus ();

  ex_ls #(.DATA_W(32), .TAG_W(4), .OP_W(6), .MEM_AW(17), .TAG_FREE(4'd0)) dut (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .clear(clear),
    .bus  (bus)
  );

  logic [7:0] ram [0:(1<<17)-1];

  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp, n_bad;
  int          pulse_cnt, pulse_cyc, wr_cnt;
  logic [3:0]  pulse_tag;
  logic [31:0] pulse_data;
  logic [16:0] wr_a [4];
  logic [7:0]  wr_d [4];
  int          wr_cyc [4];
  logic [15:0] done_map;

  // Drives one op in cycle 0 and observes cycles 0..max_c half a period after each edge.
  task automatic run_op(input logic [5:0] op, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] rg, input logic [3:0] dst, input int clr_c,
                        input int stall_lo, input int stall_hi, input int max_c);
    pulse_cnt = 0; pulse_cyc = -1; pulse_tag = 4'd0; pulse_data = 32'd0;
    wr_cnt = 0; done_map = '0;
    for (int c = 0; c <= max_c; c++) begin
      @(negedge clk);
      bus.ex_ls_en = (c == 0);
      if (c == 0) begin
        bus.ex_lsop = op; bus.ex_src1 = s1; bus.ex_src2 = s2;
        bus.ex_reg = rg; bus.ex_dest = dst;
      end
      rdy   = !(c >= stall_lo && c <= stall_hi);
      clear = (c == clr_c);
      #1;
      done_map[c] = bus.ex_ls_done;
      if (bus.en_mem_rst) begin
        pulse_cnt++;
        if (pulse_cyc < 0) pulse_cyc = c;
        pulse_tag  = bus.mem_rst_tag;
        pulse_data = bus.mem_rst_data;
      end
      if (bus.mem_wr) begin
        if (wr_cnt < 4) begin
          wr_a[wr_cnt] = bus.mem_a; wr_d[wr_cnt] = bus.mem_dout; wr_cyc[wr_cnt] = c;
        end
        wr_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    bus.ex_ls_en = 1'b0; bus.ex_lsop = '0; bus.ex_src1 = '0; bus.ex_src2 = '0;
    bus.ex_reg = '0; bus.ex_dest = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.ex_ls_done !== 1'b1) begin n_bad++; $display("FAIL rst_done got=%b exp=1", bus.ex_ls_done); end
    n_cmp++; if (bus.en_mem_rst !== 1'b0) begin n_bad++; $display("FAIL rst_en got=%b exp=0", bus.en_mem_rst); end
    n_cmp++; if (bus.mem_rst_tag !== 4'd0) begin n_bad++; $display("FAIL rst_tag got=%0h exp=0", bus.mem_rst_tag); end
    n_cmp++; if (bus.mem_rst_data !== 32'd0) begin n_bad++; $display("FAIL rst_data got=%0h exp=0", bus.mem_rst_data); end
    n_cmp++; if (bus.mem_a !== 17'd0) begin n_bad++; $display("FAIL rst_mem_a got=%0h exp=0", bus.mem_a); end
    n_cmp++; if (bus.mem_wr !== 1'b0) begin n_bad++; $display("FAIL rst_mem_wr got=%b exp=0", bus.mem_wr); end
    n_cmp++; if (bus.mem_dout !== 8'd0) begin n_bad++; $display("FAIL rst_mem_dout got=%0h exp=0", bus.mem_dout); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lw();
    run_op(LW, 32'h100, 32'h0, 32'h0, 4'd5, -1, -1, -1, 10);
    n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL lw_pulses got=%0d exp=1", pulse_cnt); end
    n_cmp++; if (pulse_cyc !== 6) begin n_bad++; $display("FAIL lw_cycle got=%0d exp=6", pulse_cyc); end
    n_cmp++; if (pulse_tag !== 4'd5) begin n_bad++; $display("FAIL lw_tag got=%0h exp=5", pulse_tag); end
    n_cmp++; if (pulse_data !== 32'h44332211) begin n_bad++; $display("FAIL lw_data got=%h exp=44332211", pulse_data); end
    n_cmp++; if (done_map[6:0] !== 7'b1000000) begin n_bad++; $display("FAIL lw_done got=%b exp=1000000", done_map[6:0]); end
  endtask

  task automatic test_narrow_loads();
    run_op(LB, 32'h7F, 32'h1, 32'h0, 4'd3, -1, -1, -1, 6);
    n_cmp++; if (pulse_cyc !== 3) begin n_bad++; $display("FAIL lb_cycle got=%0d exp=3", pulse_cyc); end
    n_cmp++; if (pulse_data !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_data got=%h exp=ffffff80", pulse_data); end
    run_op(LBU, 32'h80, 32'h0, 32'h0, 4'd4, -1, -1, -1, 6);
    n_cmp++; if (pulse_data !== 32'h00000080) begin n_bad++; $display("FAIL lbu_data got=%h exp=00000080", pulse_data); end
    n_cmp++; if (pulse_tag !== 4'd4) begin n_bad++; $display("FAIL lbu_tag got=%0h exp=4", pulse_tag); end
    run_op(LH, 32'h300, 32'h0, 32'h0, 4'd9, -1, -1, -1, 7);
    n_cmp++; if (pulse_cyc !== 4) begin n_bad++; $display("FAIL lh_cycle got=%0d exp=4", pulse_cyc); end
    n_cmp++; if (pulse_data !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_data got=%h exp=ffff8001", pulse_data); end
  endtask

  task automatic test_store();
    run_op(SH, 32'h1F0, 32'h10, 32'hABCD1234, 4'd7, -1, -1, -1, 6);
    n_cmp++; if (wr_cnt !== 2) begin n_bad++; $display("FAIL sh_writes got=%0d exp=2", wr_cnt); end
    n_cmp++; if (wr_cyc[0] !== 1 || wr_a[0] !== 17'h200 || wr_d[0] !== 8'h34) begin
      n_bad++; $display("FAIL sh_byte0 got=c%0d a%0h d%0h exp=c1 a200 d34", wr_cyc[0], wr_a[0], wr_d[0]); end
    n_cmp++; if (wr_cyc[1] !== 2 || wr_a[1] !== 17'h201 || wr_d[1] !== 8'h12) begin
      n_bad++; $display("FAIL sh_byte1 got=c%0d a%0h d%0h exp=c2 a201 d12", wr_cyc[1], wr_a[1], wr_d[1]); end
    n_cmp++; if (pulse_cyc !== 3 || pulse_tag !== 4'd7 || pulse_data !== 32'd0) begin
      n_bad++; $display("FAIL sh_pulse got=c%0d t%0h d%0h exp=c3 t7 d0", pulse_cyc, pulse_tag, pulse_data); end
    n_cmp++; if (ram[17'h201] !== 8'h12) begin n_bad++; $display("FAIL sh_ram got=%0h exp=12", ram[17'h201]); end
    run_op(SB, 32'hFFFFFFFF, 32'h1, 32'h5A, 4'd2, -1, -1, -1, 4);
    n_cmp++; if (wr_cnt !== 1 || wr_a[0] !== 17'h0 || wr_d[0] !== 8'h5A) begin
      n_bad++; $display("FAIL sb_wrap got=n%0d a%0h d%0h exp=n1 a0 d5a", wr_cnt, wr_a[0], wr_d[0]); end
    n_cmp++; if (pulse_cyc !== 2) begin n_bad++; $display("FAIL sb_cycle got=%0d exp=2", pulse_cyc); end
  endtask

  task automatic test_clear();
    run_op(LW, 32'h100, 32'h0, 32'h0, 4'd6, 2, -1, -1, 10);
    n_cmp++; if (pulse_cnt !== 0) begin n_bad++; $display("FAIL clr_lw_pulse got=%0d exp=0", pulse_cnt); end
    n_cmp++; if (done_map[3:0] !== 4'b1000) begin n_bad++; $display("FAIL clr_lw_done got=%b exp=1000", done_map[3:0]); end
    run_op(SW, 32'h400, 32'h0, 32'hDEADBEEF, 4'd8, 2, -1, -1, 10);
    n_cmp++; if (wr_cnt !== 4) begin n_bad++; $display("FAIL clr_sw_writes got=%0d exp=4", wr_cnt); end
    n_cmp++; if (pulse_cnt !== 0) begin n_bad++; $display("FAIL clr_sw_pulse got=%0d exp=0", pulse_cnt); end
    n_cmp++; if (ram[17'h403] !== 8'hDE) begin n_bad++; $display("FAIL clr_sw_ram got=%0h exp=de", ram[17'h403]); end
  endtask

  task automatic test_stall();
    run_op(LW, 32'h100, 32'h0, 32'h0, 4'd10, -1, 2, 3, 12);
    n_cmp++; if (pulse_cyc !== 8) begin n_bad++; $display("FAIL stall_lw_cycle got=%0d exp=8", pulse_cyc); end
    n_cmp++; if (pulse_data !== 32'h44332211) begin n_bad++; $display("FAIL stall_lw_data got=%h exp=44332211", pulse_data); end
    n_cmp++; if (wr_cnt !== 0) begin n_bad++; $display("FAIL stall_lw_wr got=%0d exp=0", wr_cnt); end
    run_op(SW, 32'h600, 32'h0, 32'h87654321, 4'd11, -1, 2, 2, 10);
    n_cmp++; if (wr_cnt !== 4 || wr_cyc[1] !== 3) begin
      n_bad++; $display("FAIL stall_sw_wr got=n%0d c%0d exp=n4 c3", wr_cnt, wr_cyc[1]); end
    n_cmp++; if (pulse_cyc !== 6) begin n_bad++; $display("FAIL stall_sw_cycle got=%0d exp=6", pulse_cyc); end
    n_cmp++; if (ram[17'h601] !== 8'h43) begin n_bad++; $display("FAIL stall_sw_ram got=%0h exp=43", ram[17'h601]); end
  endtask

  task automatic test_back_to_back();
    int       c1;
    logic [3:0] t1;
    run_op(LW, 32'h100, 32'h0, 32'h0, 4'd1, -1, -1, -1, 6);
    c1 = pulse_cyc; t1 = pulse_tag;
    run_op(LB, 32'h80, 32'h0, 32'h0, 4'd2, -1, -1, -1, 5);
    n_cmp++; if (c1 !== 6 || t1 !== 4'd1) begin n_bad++; $display("FAIL b2b_first got=c%0d t%0h exp=c6 t1", c1, t1); end
    n_cmp++; if (pulse_cyc !== 3 || pulse_tag !== 4'd2) begin
      n_bad++; $display("FAIL b2b_second got=c%0d t%0h exp=c3 t2", pulse_cyc, pulse_tag); end
    n_cmp++; if (pulse_data !== 32'hFFFFFF80) begin n_bad++; $display("FAIL b2b_data got=%h exp=ffffff80", pulse_data); end
  endtask

  task automatic test_nop();
    run_op(6'd0, 32'h100, 32'h0, 32'h0, 4'd3, -1, -1, -1, 5);
    n_cmp++; if (done_map[1] !== 1'b1) begin n_bad++; $display("FAIL nop_done got=%b exp=1", done_map[1]); end
    n_cmp++; if (pulse_cnt !== 0 || wr_cnt !== 0) begin
      n_bad++; $display("FAIL nop_activity got=p%0d w%0d exp=p0 w0", pulse_cnt, wr_cnt); end
  endtask

  task automatic test_rst_mid();
    int wr_after;
    @(negedge clk);
    bus.ex_ls_en = 1'b1; bus.ex_lsop = SW; bus.ex_src1 = 32'h500; bus.ex_src2 = 32'h0;
    bus.ex_reg = 32'h11223344; bus.ex_dest = 4'd12; rdy = 1'b1; clear = 1'b0;
    @(negedge clk);
    bus.ex_ls_en = 1'b0;
    #1;
    n_cmp++; if (bus.mem_wr !== 1'b1 || bus.mem_dout !== 8'h44) begin
      n_bad++; $display("FAIL rstm_byte0 got=w%b d%0h exp=w1 d44", bus.mem_wr, bus.mem_dout); end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (bus.mem_wr !== 1'b0 || bus.mem_a !== 17'd0 || bus.mem_dout !== 8'd0) begin
      n_bad++; $display("FAIL rstm_mem got=w%b a%0h d%0h exp=w0 a0 d0", bus.mem_wr, bus.mem_a, bus.mem_dout); end
    n_cmp++; if (bus.ex_ls_done !== 1'b1 || bus.en_mem_rst !== 1'b0) begin
      n_bad++; $display("FAIL rstm_ctl got=done%b en%b exp=done1 en0", bus.ex_ls_done, bus.en_mem_rst); end
    @(negedge clk);
    rst = 1'b0;
    wr_after = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (bus.mem_wr) wr_after++;
    end
    n_cmp++; if (wr_after !== 0) begin n_bad++; $display("FAIL rstm_writes got=%0d exp=0", wr_after); end
    n_cmp++; if (ram[17'h500] !== 8'h44 || ram[17'h501] !== 8'h00) begin
      n_bad++; $display("FAIL rstm_ram got=%0h,%0h exp=44,0", ram[17'h500], ram[17'h501]); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    for (int i = 0; i < (1 << 17); i++) ram[i] = 8'h00;
    ram[17'h100] = 8'h11; ram[17'h101] = 8'h22; ram[17'h102] = 8'h33; ram[17'h103] = 8'h44;
    ram[17'h080] = 8'h80;
    ram[17'h300] = 8'h01; ram[17'h301] = 8'h80;
    test_reset();
    test_lw();
    test_narrow_loads();
    test_store();
    test_clear();
    test_stall();
    test_back_to_back();
    test_nop();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
